// File: rtl/agu_k2_stage_ctrl.sv
// Stage sequencer for the k2 AGU: runs every NTT stage of one transform,
// counts emitted address pairs, drains the butterfly pipe and flags protocol errors.
module agu_k2_stage_ctrl #(
  parameter int D_WIDTH         = 4,
  parameter int STAGE_NUM       = 8,
  parameter int PAIRS_PER_STAGE = 128,
  parameter int CNT_WIDTH       = 8,
  parameter int DRAIN_LAT       = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               AGU_enable_k2,
  input  logic               BN_MA_out_en_k2,
  input  logic               AGU_done_out_k2,
  input  logic [D_WIDTH-1:0] l_AGU_out_k2,
  output logic               busy,
  output logic [D_WIDTH-1:0] stage,
  output logic               drain,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_GAP, ST_FIN} state_t;

  localparam logic [D_WIDTH-1:0]   LAST_STAGE = D_WIDTH'(STAGE_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] PAIRS      = CNT_WIDTH'(PAIRS_PER_STAGE);
  localparam logic [5:0]           DRAIN_LAST = 6'(DRAIN_LAT - 1);

  state_t                 state_reg, state_next;
  logic [D_WIDTH-1:0]     stage_reg, stage_next;
  logic [CNT_WIDTH-1:0]   pair_cnt_reg, pair_cnt_next, pair_cnt_inc;
  logic [5:0]             drain_cnt_reg, drain_cnt_next;
  logic                   err_reg, err_next;

  // Saturate so an overflowing stage can never alias back onto the expected count.
  assign pair_cnt_inc = (&pair_cnt_reg) ? pair_cnt_reg : pair_cnt_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    stage_next     = stage_reg;
    pair_cnt_next  = pair_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    err_next       = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_RUN;
          stage_next    = '0;
          pair_cnt_next = '0;
          err_next      = 1'b0;
        end
      end
      ST_RUN: begin
        if (BN_MA_out_en_k2) begin
          pair_cnt_next = pair_cnt_inc;
          if (l_AGU_out_k2 != stage_reg) err_next = 1'b1;
        end
        // A strobe coincident with done is already folded into pair_cnt_next.
        if (AGU_done_out_k2) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = '0;
          if (pair_cnt_next != PAIRS) err_next = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (BN_MA_out_en_k2) err_next = 1'b1;
        if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = (stage_reg == LAST_STAGE) ? ST_FIN : ST_GAP;
        end else begin
          drain_cnt_next = drain_cnt_reg + 6'd1;
        end
      end
      ST_GAP: begin
        stage_next    = stage_reg + 1'b1;
        pair_cnt_next = '0;
        state_next    = ST_RUN;
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // Abort overrides every other transition and leaves the error flag as it was.
    if (abort && (state_reg inside {ST_RUN, ST_DRAIN, ST_GAP})) begin
      state_next    = ST_IDLE;
      stage_next    = stage_reg;
      pair_cnt_next = pair_cnt_reg;
      err_next      = err_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      stage_reg     <= '0;
      pair_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stage_reg     <= stage_next;
      pair_cnt_reg  <= pair_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      err_reg       <= err_next;
    end
  end

  assign AGU_enable_k2 = (state_reg == ST_RUN);
  assign busy          = (state_reg inside {ST_RUN, ST_DRAIN, ST_GAP});
  assign drain         = (state_reg == ST_DRAIN);
  assign done          = (state_reg == ST_FIN);
  assign stage         = stage_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_agu_k2_stage_ctrl.sv
// Bench for agu_k2_stage_ctrl: plays the AGU side with randomized per-stage
// behaviour and checks sequencing and error reporting against a transaction model.
module tb_agu_k2_stage_ctrl;

  localparam int DW  = 4;
  localparam int SN  = 3;
  localparam int PPS = 4;
  localparam int CW  = 3;
  localparam int DL  = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, strobe, agu_done;
  logic [DW-1:0] l_tag;
  logic          en, busy, drain, done, err;
  logic [DW-1:0] stage;

  agu_k2_stage_ctrl #(
    .D_WIDTH(DW), .STAGE_NUM(SN), .PAIRS_PER_STAGE(PPS), .CNT_WIDTH(CW), .DRAIN_LAT(DL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .AGU_enable_k2(en), .BN_MA_out_en_k2(strobe), .AGU_done_out_k2(agu_done),
    .l_AGU_out_k2(l_tag), .busy(busy), .stage(stage), .drain(drain),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit err_exp;

  // Per-stage AGU behaviour of the next transform.
  int cfg_n[SN];
  int cfg_bad[SN];
  int cfg_off[SN];
  bit cfg_late[SN];
  bit cfg_merge[SN];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nominal();
    for (int s = 0; s < SN; s++) begin
      cfg_n[s] = PPS; cfg_bad[s] = -1; cfg_off[s] = 1; cfg_late[s] = 0; cfg_merge[s] = 0;
    end
  endtask

  task automatic start_xfer();
    start = 1'b1;
    tick();
    start = 1'b0;
    err_exp = 1'b0;
    check_val("start_busy", busy, 1);
    check_val("start_en", en, 1);
    check_val("start_stage", stage, 0);
    check_val("start_err", err, 0);
    check_val("start_drain", drain, 0);
  endtask

  // Emits the configured strobes and the done flag; returns in the first DRAIN cycle.
  task automatic emit_stage(input int s);
    bit merged;
    merged = 1'b0;
    for (int i = 0; i < cfg_n[s]; i++) begin
      strobe = 1'b1;
      l_tag  = (i == cfg_bad[s]) ? DW'(s + cfg_off[s]) : DW'(s);
      if (i == cfg_bad[s]) err_exp = 1'b1;
      start  = ($urandom_range(0, 7) == 0);
      if (i == cfg_n[s] - 1 && cfg_merge[s]) begin
        agu_done = 1'b1;
        merged   = 1'b1;
      end
      tick();
      strobe = 1'b0;
      start  = 1'b0;
      if (merged) break;
      check_val("run_err", err, err_exp);
      check_val("run_en", en, 1);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check_val("idle_stage", stage, s);
      end
    end
    if (!merged) begin
      agu_done = 1'b1;
      tick();
    end
    agu_done = 1'b0;
    if (cfg_n[s] != PPS) err_exp = 1'b1;
    check_val("drain_entry", drain, 1);
    check_val("drain_en", en, 0);
    check_val("drain_stage", stage, s);
    check_val("drain_err", err, err_exp);
  endtask

  // Runs out the DRAIN window and the following GAP or FIN.
  task automatic finish_drain(input int s);
    int cnt;
    cnt = 0;
    while (drain === 1'b1 && cnt < 64) begin
      cnt++;
      strobe = (cnt == 1) && cfg_late[s];
      l_tag  = DW'(s);
      if (strobe) err_exp = 1'b1;
      tick();
    end
    strobe = 1'b0;
    check_val("drain_len", cnt, DL);
    check_val("post_drain_err", err, err_exp);
    if (s < SN - 1) begin
      check_val("gap_en", en, 0);
      check_val("gap_busy", busy, 1);
      check_val("gap_drain", drain, 0);
      tick();
      check_val("next_en", en, 1);
      check_val("next_stage", stage, s + 1);
    end else begin
      check_val("fin_done", done, 1);
      check_val("fin_busy", busy, 0);
      check_val("fin_stage", stage, SN - 1);
      tick();
      check_val("after_done", done, 0);
      check_val("after_busy", busy, 0);
      check_val("final_err", err, err_exp);
      check_val("final_stage", stage, SN - 1);
    end
  endtask

  task automatic run_xfer();
    start_xfer();
    for (int s = 0; s < SN; s++) begin
      emit_stage(s);
      finish_drain(s);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; strobe = 1'b0; agu_done = 1'b0; l_tag = '0;
    tick(); tick();
    rst = 1'b0;
    check_val("rst_en", en, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_stage", stage, 0);
    check_val("rst_drain", drain, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);

    // Nominal transform.
    set_nominal();
    run_xfer();

    // Short stage 1: error from DRAIN entry until the next start.
    set_nominal();
    cfg_n[1] = 3;
    run_xfer();

    // Wrong stage tag (l=2 while stage=0) and a late strobe in stage 0.
    set_nominal();
    cfg_bad[0] = 0; cfg_off[0] = 2;
    run_xfer();
    set_nominal();
    cfg_late[0] = 1;
    run_xfer();

    // Overlong stage: 12 strobes must not wrap back to the expected count.
    set_nominal();
    cfg_n[0] = 12;
    run_xfer();

    // Abort together with drain expiry in stage 1; stage 0 was short so err is set.
    set_nominal();
    cfg_n[0] = 3;
    start_xfer();
    emit_stage(0);
    finish_drain(0);
    emit_stage(1);
    tick();
    check_val("abort_pre_drain", drain, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_en", en, 0);
    check_val("abort_drain", drain, 0);
    check_val("abort_done", done, 0);
    check_val("abort_err", err, 1);
    tick();
    check_val("abort_no_done", done, 0);
    set_nominal();
    run_xfer();

    // Abort in RUN together with AGU done: no drain, err untouched.
    set_nominal();
    start_xfer();
    agu_done = 1'b1; abort = 1'b1;
    tick();
    agu_done = 1'b0; abort = 1'b0;
    check_val("abort_run_drain", drain, 0);
    check_val("abort_run_busy", busy, 0);
    check_val("abort_run_err", err, 0);

    // Reset during stage 2 RUN, with start in the same cycle.
    set_nominal();
    cfg_bad[0] = 1; cfg_off[0] = 5;
    start_xfer();
    for (int s = 0; s < 2; s++) begin
      emit_stage(s);
      finish_drain(s);
    end
    check_val("pre_rst_stage", stage, 2);
    strobe = 1'b1; l_tag = 4'd2; rst = 1'b1; start = 1'b1;
    tick();
    strobe = 1'b0; rst = 1'b0; start = 1'b0;
    check_val("mid_rst_en", en, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_stage", stage, 0);
    check_val("mid_rst_err", err, 0);
    check_val("mid_rst_drain", drain, 0);
    check_val("mid_rst_done", done, 0);
    tick();
    check_val("rst_start_ignored", busy, 0);

    // Randomized transforms.
    for (int t = 0; t < 30; t++) begin
      for (int s = 0; s < SN; s++) begin
        cfg_n[s]     = ($urandom_range(0, 9) < 7) ? PPS : int'($urandom_range(0, 12));
        cfg_bad[s]   = (cfg_n[s] > 0 && $urandom_range(0, 9) == 0) ?
                       int'($urandom_range(0, cfg_n[s] - 1)) : -1;
        cfg_off[s]   = int'($urandom_range(1, 15));
        cfg_late[s]  = ($urandom_range(0, 9) == 0);
        cfg_merge[s] = (cfg_n[s] > 0) && ($urandom_range(0, 1) == 1);
      end
      run_xfer();
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/agu_k2_stage_ctrl.md
Name: agu_k2_stage_ctrl

Overview:
- Sequences the k2 address-generation pipeline (AGU core + order translator) through every NTT stage of one transform.
- Raises the AGU enable per stage and counts the bank/memory-address pairs it emits.
- Waits for the AGU's done flag, then drains the butterfly pipeline for a fixed latency before opening the next stage.
- Sits between the top-level NTT command interface and the AGU top; reports progress, completion and protocol errors.

Parameters:
- D_WIDTH, 4, width of the stage index (matches `D_width).
- STAGE_NUM, 8, NTT stages per transform (log2 N); legal range 1..2**D_WIDTH.
- PAIRS_PER_STAGE, 128, address pairs the AGU must emit per stage (N/2).
- CNT_WIDTH, 8, pair-counter width; must satisfy 2**CNT_WIDTH > PAIRS_PER_STAGE.
- DRAIN_LAT, 6, cycles to wait after AGU done before the next stage (butterfly + writeback latency); legal range 1..63.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to run a full transform; honoured only in IDLE.
- abort  in  1  cancel the current transform; ignored in IDLE.
- AGU_enable_k2  out  1  enable to the AGU top.
- BN_MA_out_en_k2  in  1  valid strobe for one address pair from the AGU top.
- AGU_done_out_k2  in  1  end-of-stage flag from the AGU top.
- l_AGU_out_k2  in  D_WIDTH  stage index reported by the AGU top.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- stage  out  D_WIDTH  current stage index.
- drain  out  1  high during the DRAIN state.
- done  out  1  one-cycle pulse when the transform completes.
- err  out  1  sticky protocol-error flag; cleared only by rst or an accepted start.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE; AGU_enable_k2=0, busy=0, stage=0, drain=0, done=0, err=0; pair counter=0, drain counter=0.
- States: IDLE, RUN, DRAIN, GAP, FIN.
- IDLE: start=1 -> RUN. Clear stage, pair count and err. busy=1 and AGU_enable_k2=1 from the next cycle.
- RUN:
  - AGU_enable_k2=1.
  - Each cycle with BN_MA_out_en_k2=1, pair count +1 (saturates at all-ones).
  - Any strobe with l_AGU_out_k2 != stage sets err.
  - On AGU_done_out_k2=1 -> DRAIN. If a strobe arrives in the same cycle, it is counted before the check.
  - Check on exit: final count != PAIRS_PER_STAGE sets err.
- DRAIN:
  - AGU_enable_k2=0, drain=1, duration exactly DRAIN_LAT cycles.
  - Any BN_MA_out_en_k2 here sets err and is not counted.
  - After DRAIN_LAT cycles: if stage==STAGE_NUM-1 -> FIN, else -> GAP.
- GAP: one cycle, AGU_enable_k2=0; stage+1; pair count cleared -> RUN. This guarantees at least one low enable cycle between stages so the AGU restarts.
- FIN: done=1 for exactly one cycle; busy falls in the same cycle -> IDLE. stage holds its final value until the next start.
- abort=1 in RUN/DRAIN/GAP: next cycle state=IDLE, AGU_enable_k2=0, busy=0, drain=0, done not pulsed, err unchanged.
- Simultaneous events:
  - abort has priority over AGU_done_out_k2 and over the drain expiry.
  - start outside IDLE is ignored; it does not restart and does not set err.
- Stage latency, from the first enable cycle: AGU pipeline time + DRAIN_LAT + 1 GAP cycle.
- Width rules: stage wraps never (bounded by STAGE_NUM-1). Comparisons are unsigned and zero-extended.

Test Plan:
- Nominal, STAGE_NUM=3, PAIRS_PER_STAGE=4, DRAIN_LAT=2. Model emits 4 strobes with matching l, then done -> three RUN/DRAIN windows; stage 0,1,2; exactly 2 GAP cycles with enable low; done pulses once; err=0; busy low the cycle after done.
- Count mismatch: stage 1 model emits 3 strobes then done -> err=1 at DRAIN entry; sequencing still completes and done pulses; err remains 1 until the next start clears it.
- Wrong stage tag: a strobe with l_AGU_out_k2=2 while stage=0 -> err=1 on the next cycle.
- Late strobe: a strobe during DRAIN cycle 1 -> err=1; pair count for the next stage starts at 0.
- Abort in DRAIN of stage 1, together with drain expiry in the same cycle -> IDLE next cycle; no done pulse; enable=0; start then restarts at stage 0 with err cleared.
- Reset mid-RUN: rst=1 for one cycle at stage 2 -> all outputs 0 on the following cycle. start during busy is ignored, and a start in the same cycle as rst is ignored.
